datamover_loopback_checker: RTL

Parametrised multi-burst S2MM-write / MM2S-read-back self-checker for the AXI DataMover. On a start edge it writes NUM bursts of a deterministic pattern through the S2MM command, data and status channels, then reads each burst back via MM2S and compares it beat-by-beat. It reports mismatch count, status errors and pass/fail, and sits beside the DataMover as a board-level memory-path validation engine driven from VIO.

---
 rtl/datamover_loopback_checker.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/datamover_loopback_checker.sv
// rtl/datamover_loopback_checker.sv - multi-burst S2MM write / MM2S read-back self-checker for the AXI DataMover
//
// On a rising edge of i_start, writes i_num_bursts bursts of i_beats beats of a
// counting pattern through the S2MM command/data/status channels, reads each
// burst back through MM2S and compares it beat by beat.
//
// Optional build macro: DM_CHECK_TIMEOUT_EN enables the stall watchdog
// (o_timeout). Without it o_timeout is always 0 and a stalled run waits forever.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_start                   level; rising edge starts a run (ignored unless idle)
//   i_beats / i_num_bursts    beats per burst / bursts per run, sampled at start
//   i_base_addr / i_seed      first burst byte address / pattern seed, sampled at start
//   o_s2mm_cmd_*              S2MM command stream (ADDR_WIDTH+40 bits)
//   o_s2mm_t*                 S2MM write data stream (tkeep all ones)
//   i_s2mm_sts_*              S2MM status stream (bit 7 OKAY, bits 3:0 tag)
//   o_mm2s_cmd_*              MM2S command stream, same format as S2MM
//   i_mm2s_t*                 MM2S read data stream
//   o_busy / o_done / o_pass  run in progress / one-cycle end pulse / result
//   o_err_cnt                 saturating mismatching-beat count
//   o_sts_err / o_cfg_err     sticky status-or-length error / zero config
//   o_burst_cnt               bursts completed
//   o_timeout                 watchdog fired
module datamover_loopback_checker #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 9,
  parameter int NB_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [LEN_WIDTH-1:0]    i_beats,
  input  logic [NB_WIDTH-1:0]     i_num_bursts,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [31:0]             i_seed,
  output logic [ADDR_WIDTH+39:0]  o_s2mm_cmd_tdata,
  output logic                    o_s2mm_cmd_tvalid,
  input  logic                    i_s2mm_cmd_tready,
  output logic [DATA_WIDTH-1:0]   o_s2mm_tdata,
  output logic [DATA_WIDTH/8-1:0] o_s2mm_tkeep,
  output logic                    o_s2mm_tvalid,
  output logic                    o_s2mm_tlast,
  input  logic                    i_s2mm_tready,
  input  logic [7:0]              i_s2mm_sts_tdata,
  input  logic                    i_s2mm_sts_tvalid,
  output logic                    o_s2mm_sts_tready,
  output logic [ADDR_WIDTH+39:0]  o_mm2s_cmd_tdata,
  output logic                    o_mm2s_cmd_tvalid,
  input  logic                    i_mm2s_cmd_tready,
  input  logic [DATA_WIDTH-1:0]   i_mm2s_tdata,
  input  logic                    i_mm2s_tvalid,
  input  logic                    i_mm2s_tlast,
  output logic                    o_mm2s_tready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [15:0]             o_err_cnt,
  output logic                    o_sts_err,
  output logic                    o_cfg_err,
  output logic [NB_WIDTH-1:0]     o_burst_cnt,
  output logic                    o_timeout
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_WR_DATA, S_WR_STS, S_RD_CMD, S_RD_DATA, S_NEXT, S_DONE
  } state_t;

  state_t state, state_next;

  logic                  start_q;
  logic                  start_edge;
  logic [LEN_WIDTH-1:0]  beats_r;
  logic [NB_WIDTH-1:0]   nb_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           burst_w;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [NB_WIDTH-1:0]   burst_cnt;
  logic [NB_WIDTH-1:0]   burst_inc;
  logic [15:0]           err_cnt;
  logic                  sts_err, cfg_err, timeout_r, pass_q, pass_now;
  logic [22:0]           btt;
  logic [31:0]           cur_w;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  last_beat, sts_ok, zero_cfg, wd_fire;
  logic [ADDR_WIDTH+39:0] cmd_word;
  logic                  s2mm_cmd_v, s2mm_v, sts_rdy, mm2s_cmd_v, mm2s_rdy;

  assign start_edge = i_start & ~start_q;
  assign zero_cfg   = (i_beats == '0) || (i_num_bursts == '0);
  assign btt        = 23'(beats_r) * 23'(BYTES);
  assign burst_inc  = burst_cnt + NB_WIDTH'(1);
  assign last_beat  = (beat_cnt == beats_r - LEN_WIDTH'(1));
  // Write and read of one burst both regenerate from the burst's start word.
  assign cur_w      = burst_w + 32'(beat_cnt);
  // OKAY set, no error bits, tag of the burst in flight.
  assign sts_ok     = (i_s2mm_sts_tdata[7:4] == 4'b1000) &&
                      (i_s2mm_sts_tdata[3:0] == burst_cnt[3:0]);
  assign cmd_word   = {4'd0, burst_cnt[3:0], addr_r, 1'b0, 1'b1, 6'd0, 1'b1, btt};
  assign pass_now   = (err_cnt == 16'd0) && !sts_err && !cfg_err && !timeout_r;

  always_comb begin
    pattern = '0;
    for (int j = 0; j < LANES; j++) begin
      pattern[j*32 +: 32] = cur_w + 32'(j);
    end
  end

`ifdef DM_CHECK_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_active, hs;

  assign wd_active = (state == S_WR_CMD) || (state == S_WR_DATA) || (state == S_WR_STS) ||
                     (state == S_RD_CMD) || (state == S_RD_DATA);
  assign hs = (s2mm_cmd_v & i_s2mm_cmd_tready) | (s2mm_v & i_s2mm_tready) |
              (sts_rdy & i_s2mm_sts_tvalid) | (mm2s_cmd_v & i_mm2s_cmd_tready) |
              (mm2s_rdy & i_mm2s_tvalid);
  // Only fires on a cycle with no handshake, so no accepted beat is ever dropped.
  assign wd_fire = wd_active && !hs && (wd_cnt >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !wd_active || hs) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s2mm_cmd_v = 1'b0;
    s2mm_v     = 1'b0;
    sts_rdy    = 1'b0;
    mm2s_cmd_v = 1'b0;
    mm2s_rdy   = 1'b0;
    case (state)
      S_IDLE:    if (start_edge) state_next = zero_cfg ? S_DONE : S_WR_CMD;
      S_WR_CMD: begin
        s2mm_cmd_v = 1'b1;
        if (i_s2mm_cmd_tready) state_next = S_WR_DATA;
      end
      S_WR_DATA: begin
        s2mm_v = 1'b1;
        if (i_s2mm_tready && last_beat) state_next = S_WR_STS;
      end
      S_WR_STS: begin
        sts_rdy = 1'b1;
        if (i_s2mm_sts_tvalid) state_next = sts_ok ? S_RD_CMD : S_DONE;
      end
      S_RD_CMD: begin
        mm2s_cmd_v = 1'b1;
        if (i_mm2s_cmd_tready) state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        mm2s_rdy = 1'b1;
        if (i_mm2s_tvalid && (i_mm2s_tlast || last_beat)) state_next = S_NEXT;
      end
      S_NEXT:    state_next = (burst_inc == nb_r) ? S_DONE : S_WR_CMD;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (wd_fire) state_next = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= 1'b0;
      beats_r   <= '0;
      nb_r      <= '0;
      addr_r    <= '0;
      burst_w   <= '0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      err_cnt   <= '0;
      sts_err   <= 1'b0;
      cfg_err   <= 1'b0;
      timeout_r <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      start_q <= i_start;
      case (state)
        S_IDLE: if (start_edge) begin
          beats_r   <= i_beats;
          nb_r      <= i_num_bursts;
          addr_r    <= i_base_addr;
          burst_w   <= i_seed;
          beat_cnt  <= '0;
          burst_cnt <= '0;
          err_cnt   <= '0;
          sts_err   <= 1'b0;
          cfg_err   <= zero_cfg;
          timeout_r <= 1'b0;
          pass_q    <= 1'b0;
        end
        S_WR_DATA: if (i_s2mm_tready) begin
          beat_cnt <= last_beat ? '0 : beat_cnt + LEN_WIDTH'(1);
        end
        S_WR_STS: if (i_s2mm_sts_tvalid && !sts_ok) begin
          sts_err <= 1'b1;
        end
        S_RD_DATA: if (i_mm2s_tvalid) begin
          if ((i_mm2s_tdata != pattern) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
          // Early tlast or missing tlast on the final beat are both length errors.
          if (i_mm2s_tlast != last_beat) sts_err <= 1'b1;
          beat_cnt <= (i_mm2s_tlast || last_beat) ? '0 : beat_cnt + LEN_WIDTH'(1);
        end
        S_NEXT: begin
          burst_cnt <= burst_inc;
          addr_r    <= addr_r + ADDR_WIDTH'(btt);
          burst_w   <= burst_w + 32'(beats_r);
        end
        S_DONE: pass_q <= pass_now;
        default: ;
      endcase
      if (wd_fire) timeout_r <= 1'b1;
    end
  end

  assign o_s2mm_cmd_tvalid = s2mm_cmd_v;
  assign o_s2mm_cmd_tdata  = s2mm_cmd_v ? cmd_word : '0;
  assign o_mm2s_cmd_tvalid = mm2s_cmd_v;
  assign o_mm2s_cmd_tdata  = mm2s_cmd_v ? cmd_word : '0;
  assign o_s2mm_tvalid     = s2mm_v;
  assign o_s2mm_tdata      = s2mm_v ? pattern : '0;
  assign o_s2mm_tlast      = s2mm_v & last_beat;
  assign o_s2mm_tkeep      = '1;
  assign o_s2mm_sts_tready = sts_rdy;
  assign o_mm2s_tready     = mm2s_rdy;
  assign o_busy            = (state != S_IDLE) && (state != S_DONE);
  assign o_done            = (state == S_DONE);
  assign o_pass            = (state == S_DONE) ? pass_now : pass_q;
  assign o_err_cnt         = err_cnt;
  assign o_sts_err         = sts_err;
  assign o_cfg_err         = cfg_err;
  assign o_burst_cnt       = burst_cnt;
  assign o_timeout         = timeout_r;

endmodule
